pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of one pipeline field in bits.
REQ-002 SHALL provide parameter NUM_FIELDS, default 4, number of fields carried (instruction, operand A, operand B, immediate).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream holds a valid field set.
REQ-006 in_ready  output  1  stage can accept this cycle.
REQ-007 in_data  input  NUM_FIELDS*DATA_W  packed fields; field k occupies bits [k*DATA_W +: DATA_W].
REQ-008 flush  input  1  discard all held entries (branch or exception squash).
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream consumes this cycle.
REQ-011 out_data  output  NUM_FIELDS*DATA_W  oldest held field set.
REQ-012 occupancy  output  2  number of entries held (0, 1 or 2).

Function
REQ-013 SHALL accept an entry only on a cycle where in_valid and in_ready are both 1 at the clock edge, and SHALL release an entry only on a cycle where out_valid and out_ready are both 1.
REQ-014 SHALL present an accepted entry on out_data with out_valid=1 exactly one cycle after acceptance when the stage was empty.
REQ-015 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-016 SHALL deliver entries in acceptance order; no entry is dropped or duplicated except by flush or rst.
REQ-017 With skid enabled, SHALL implement three states: EMPTY (occupancy 0), FULL (main register valid, occupancy 1) and SKID (main and skid registers valid, occupancy 2).
REQ-018 EMPTY: on accept, go to FULL with the new entry in the main register.
REQ-019 FULL: accept with release -> FULL, new entry in main; accept without release -> SKID, new entry in skid; release without accept -> EMPTY; neither -> FULL.
REQ-020 SKID: in_ready=0; on release, move skid to main and go to FULL; otherwise hold.
REQ-021 With skid enabled, in_ready SHALL be a register output equal to 1 in EMPTY and FULL and 0 in SKID, with no combinational path from out_ready.
REQ-022 flush=1 at an edge SHALL go to EMPTY and clear out_valid; an input accepted in that cycle SHALL be discarded; a release completing in that cycle SHALL count as consumed.
REQ-023 Flush SHALL leave data registers unchanged; only the valid state is cleared.
REQ-024 rst SHALL take priority over flush; flush SHALL take priority over all handshakes.
REQ-025 occupancy SHALL equal the number of valid entries after each edge and SHALL never exceed 2.

Reset
REQ-026 While rst=1 at an edge, SHALL enter EMPTY, set out_valid=0, out_data=0, occupancy=0 and in_ready=1, with the skid register zeroed.
REQ-027 in_valid and out_ready SHALL be ignored in any cycle where rst=1.
REQ-028 Asserting rst mid-operation, including in SKID, SHALL discard all entries with no output handshake in the following cycle.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: the two-entry skid behaviour of REQ-017 to REQ-021 SHALL be implemented.
REQ-030 Macro PIPE_STAGE_SKID_EN undefined: SHALL use a single register; in_ready = !out_valid || out_ready, combinational; occupancy is 0 or 1; SKID state absent; all other requirements unchanged.

Verification
REQ-031 After rst, in_valid=1 with in_data fields {0x11,0x22,0x33,0x44} and out_ready=1 -> out_valid=1 with the same fields one cycle later; occupancy=1.
REQ-032 SKID_EN: out_ready=0, accept A then B -> occupancy=2, in_ready=0, out_data=A stable; raise out_ready -> A then B on consecutive cycles; in_ready back to 1 after A leaves.
REQ-033 Continuous in_valid=1 and out_ready=1 with an incrementing pattern 0..99 -> 100 outputs in order, one per cycle, no bubbles after the first.
REQ-034 In SKID state, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; the flushed input never appears.
REQ-035 rst asserted while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0, occupancy=0.
REQ-036 Macro undefined: out_ready=0 with stage full -> in_ready=0 the same cycle; out_ready=1 -> in_ready=1 combinationally and back-to-back transfer sustained.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with ready/valid handshakes, flush and synchronous reset.
// Define PIPE_STAGE_SKID_EN for the two-entry skid version with a registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [1:0]                   occupancy
);
    localparam int W = NUM_FIELDS * DATA_W;

    logic [W-1:0] main_r;
    logic         out_valid_r;
    logic [1:0]   occupancy_r;
    logic         accept_s;
    logic         release_s;

    assign out_data  = main_r;
    assign out_valid = out_valid_r;
    assign occupancy = occupancy_r;
    assign release_s = out_valid_r && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t       state_r;
    logic [W-1:0] skid_r;
    logic         in_ready_r;

    assign in_ready = in_ready_r;
    assign accept_s = in_valid && in_ready_r;

    // Stage FSM: main/skid data, valid state and all status outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_r      <= {W{1'b0}};
            skid_r      <= {W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else if (flush) begin
            // Only valid state is dropped; data registers keep their contents.
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_r      <= in_data;
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        occupancy_r <= 2'd1;
                    end
                end
                ST_FULL: begin
                    if (accept_s && release_s) begin
                        main_r <= in_data;
                    end else if (accept_s) begin
                        skid_r      <= in_data;
                        state_r     <= ST_SKID;
                        in_ready_r  <= 1'b0;
                        occupancy_r <= 2'd2;
                    end else if (release_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        occupancy_r <= 2'd0;
                    end
                end
                ST_SKID: begin
                    if (release_s) begin
                        main_r      <= skid_r;
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b1;
                        occupancy_r <= 2'd1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    occupancy_r <= 2'd0;
                end
            endcase
        end
    end
`else
    logic in_ready_s;

    // Single-register stage can refill in the same cycle the downstream drains it.
    assign in_ready_s = !out_valid_r || out_ready;
    assign in_ready   = in_ready_s;
    assign accept_s   = in_valid && in_ready_s;

    // Single data register with its valid flag and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r      <= {W{1'b0}};
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else if (accept_s) begin
            main_r      <= in_data;
            out_valid_r <= 1'b1;
            occupancy_r <= 2'd1;
        end else if (release_s) begin
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end
    end
`endif

endmodule
